// File: rtl/spike_fifo.sv
// Synchronous FIFO with sticky overflow/underflow flags and flush.
// Define SPIKE_FIFO_FWFT_EN for first-word-fall-through reads; default is registered 1-cycle read.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef BUFFER_DEPTH
`define BUFFER_DEPTH 16
`endif

module spike_fifo #(
  parameter int  DATA_WIDTH    = `DATA_WIDTH,
  parameter int  DEPTH         = `BUFFER_DEPTH,
  parameter int  AFULL_THRESH  = DEPTH - 1,
  parameter int  AEMPTY_THRESH = 1,
  localparam int CNT_W         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_accept;
  logic                  rd_accept;

  // DEPTH need not be a power of two, so wrap is an explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(DEPTH));
  assign almost_empty = (count <= CNT_W'(AEMPTY_THRESH));
  assign almost_full  = (count >= CNT_W'(AFULL_THRESH));
  assign din_ready    = !full;

  assign wr_accept = din_valid && !full;
  assign rd_accept = read_en && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_accept) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_accept && !rd_accept)      count <= count + CNT_W'(1);
      else if (rd_accept && !wr_accept) count <= count - CNT_W'(1);
      if (din_valid && full) overflow  <= 1'b1;
      if (read_en && empty)  underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept && !flush) mem[wr_ptr] <= din;
  end

`ifdef SPIKE_FIFO_FWFT_EN
  assign dout       = empty ? '0 : mem[rd_ptr];
  assign dout_valid = !empty;
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (flush) begin
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_accept;
      if (rd_accept) dout <= mem[rd_ptr];
    end
  end
`endif

endmodule
